program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot-time loader upstream of the processor core. Accepts a byte stream over a
//  valid/ready handshake, assembles big-endian 32-bit words and writes them into
//  the instruction memory. Holds the core in reset until a complete image is loaded.
// PARAMETERS
//  ADDR_WIDTH  8    word-address width of instruction memory port
//  MAX_WORDS   256  largest accepted image, in words (must be <= 2**ADDR_WIDTH)
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst         in   1           asynchronous, active-high reset
//  start       in   1           1-cycle pulse: begin (re)load; honoured in IDLE/DONE/ERROR only
//  in_byte     in   8           stream data byte
//  in_valid    in   1           in_byte valid
//  in_ready    out  1           loader can accept a byte this cycle
//  imem_we     out  1           instruction-memory write strobe (1 cycle per word)
//  imem_addr   out  ADDR_WIDTH  word address, 0-based
//  imem_wdata  out  32          assembled instruction word
//  cpu_rst_n   out  1           active-low reset to core; 1 only in DONE
//  busy        out  1           1 in LEN_HI, LEN_LO, DATA, WRITE
//  done        out  1           1 in DONE
//  error       out  1           1 in ERROR
//  word_count  out  16          length N latched from header
// BEHAVIOUR
//  Single clock. Reset is asynchronous and active-high, named rst.
//  Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0,
//   cpu_rst_n 0, busy 0, done 0, error 0, word_count 0, byte counter 0.
//  Byte accepted on a rising edge where in_valid && in_ready; else held, no state change.
//  Stream format: N[15:8], N[7:0], then N words, each MSB byte first.
//  FSM:
//   IDLE   : in_ready 0. start -> LEN_HI, clear counters.
//   LEN_HI : in_ready 1. accept -> word_count[15:8]=byte, LEN_LO.
//   LEN_LO : in_ready 1. accept -> word_count[7:0]=byte; then
//            N==0 -> DONE; N>MAX_WORDS -> ERROR; else DATA.
//   DATA   : in_ready 1. shift byte into 32-bit assembly reg (new byte to [7:0]),
//            byte_cnt++ (2-bit). 4th byte accepted -> WRITE.
//   WRITE  : in_ready 0, imem_we 1 for exactly one cycle, imem_addr = word index,
//            imem_wdata = assembled word. Next: index+1 == N -> DONE, else DATA.
//   DONE   : in_ready 0, cpu_rst_n 1, done 1. start -> LEN_HI (cpu_rst_n drops next cycle).
//   ERROR  : in_ready 0, cpu_rst_n 0, error 1. start -> LEN_HI. Only start/rst exit.
//  start while busy is ignored. in_valid outside busy states is ignored (no overflow).
//  Timing: last byte of word accepted at edge t -> imem_we high cycle t..t+1;
//   after last word, done and cpu_rst_n rise one edge after the WRITE cycle.
//  imem_we never asserted outside WRITE; addresses strictly 0..N-1, no wrap.
//  Reset mid-load: immediately return to reset values; partial image left in memory,
//   cpu_rst_n stays 0 until a later complete load.
//  Registered outputs only; no combinational path in_valid -> in_ready.
// TESTING
//  1. start, stream 00 02 | 20 08 00 05 | AC 08 00 00 -> writes addr0=32'h20080005,
//     addr1=32'hAC080000, 2 imem_we pulses, then done=1, cpu_rst_n=1.
//  2. Header 00 00 -> DONE one edge after N[7:0] accepted, no imem_we.
//  3. Header 01 01 (257 > MAX_WORDS) -> ERROR, error=1, in_ready=0, cpu_rst_n=0;
//     subsequent start + valid 1-word image -> DONE.
//  4. in_valid toggled every other cycle during 1-word image -> same word written,
//     byte accepted only when in_valid&&in_ready; in_ready=0 during WRITE.
//  5. rst asserted after 6 bytes of a 3-word load -> all outputs to reset values at once;
//     start after release reloads from LEN_HI correctly.
//  6. start pulsed in DATA -> ignored; pulsed in DONE -> cpu_rst_n 0, reload begins.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: byte stream -> big-endian words -> imem.
// Holds the core in reset until a complete image has been written.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]  state, nstate;
  logic [15:0] n_wc;
  logic [31:0] asm_q, n_asm;
  logic [1:0]  bcnt, n_bcnt;
  logic [15:0] idx, n_idx;
  logic [15:0] len;
  logic        accept;

  assign accept = in_valid && in_ready;
  assign len    = {word_count[15:8], in_byte};

  // Next-state and datapath decode
  always_comb begin
    nstate = state;
    n_wc   = word_count;
    n_asm  = asm_q;
    n_bcnt = bcnt;
    n_idx  = idx;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          nstate = S_LEN_HI;
          n_bcnt = 2'd0;
          n_idx  = 16'd0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          n_wc[15:8] = in_byte;
          nstate     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          n_wc[7:0] = in_byte;
          if (len == 16'd0)
            nstate = S_DONE;
          else if (len > 16'(MAX_WORDS))
            nstate = S_ERROR;
          else
            nstate = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          n_asm  = {asm_q[23:0], in_byte};
          n_bcnt = bcnt + 2'd1;
          if (bcnt == 2'd3)
            nstate = S_WRITE;
        end
      end
      S_WRITE: begin
        n_idx = idx + 16'd1;
        if (idx + 16'd1 == word_count)
          nstate = S_DONE;
        else
          nstate = S_DATA;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      word_count <= 16'd0;
      asm_q      <= 32'd0;
      bcnt       <= 2'd0;
      idx        <= 16'd0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= nstate;
      word_count <= n_wc;
      asm_q      <= n_asm;
      bcnt       <= n_bcnt;
      idx        <= n_idx;
      in_ready   <= (nstate == S_LEN_HI) ||
                    (nstate == S_LEN_LO) ||
                    (nstate == S_DATA);
      imem_we    <= (nstate == S_WRITE);
      if (nstate == S_WRITE) begin
        imem_addr  <= n_idx[ADDR_WIDTH-1:0];
        imem_wdata <= n_asm;
      end
      cpu_rst_n  <= (nstate == S_DONE);
      busy       <= (nstate == S_LEN_HI) ||
                    (nstate == S_LEN_LO) ||
                    (nstate == S_DATA)   ||
                    (nstate == S_WRITE);
      done       <= (nstate == S_DONE);
      error      <= (nstate == S_ERROR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Immediate-assertion checks with a write-strobe log.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int base;
  logic [7:0]  wa [64];
  logic [31:0] wd [64];

  program_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Log every write strobe seen at a rising edge
  always @(posedge clk) begin
    if (imem_we) begin
      wa[we_cnt % 64] <= imem_addr;
      wd[we_cnt % 64] <= imem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      @(negedge clk); in_valid = 1'b0;
    end
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) chk("send_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_we", {31'b0, imem_we}, 32'd0);
    chk("rst_addr", {24'b0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    chk("rst_flags", {29'b0, busy, done, error}, 32'd0);
    chk("rst_wc", {16'b0, word_count}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'b0, in_ready}, 32'd0);

    // Test 1: two-word image
    base = we_cnt;
    pulse_start();
    chk("t1_busy", {30'b0, busy, in_ready}, 32'd3);
    send(8'h00, 0); send(8'h02, 0);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'hAC, 0); send(8'h08, 0); send(8'h00, 0); send(8'h00, 0);
    chk("t1_write_we_rdy", {30'b0, imem_we, in_ready}, 32'd2);
    @(posedge clk); #1;
    chk("t1_done", {28'b0, done, cpu_rst_n, busy, imem_we}, 32'hC);
    chk("t1_wecnt", we_cnt - base, 32'd2);
    chk("t1_a0", {24'b0, wa[base % 64]}, 32'd0);
    chk("t1_d0", wd[base % 64], 32'h20080005);
    chk("t1_a1", {24'b0, wa[(base + 1) % 64]}, 32'd1);
    chk("t1_d1", wd[(base + 1) % 64], 32'hAC080000);
    chk("t1_wc", {16'b0, word_count}, 32'd2);

    // Test 2: empty image, start from DONE
    base = we_cnt;
    pulse_start();
    chk("t2_restart", {29'b0, cpu_rst_n, done, busy}, 32'd1);
    send(8'h00, 0); send(8'h00, 0);
    chk("t2_done", {29'b0, done, cpu_rst_n, busy}, 32'd6);
    chk("t2_nowe", we_cnt - base, 32'd0);

    // Test 3: oversize header, then recovery
    base = we_cnt;
    pulse_start();
    send(8'h01, 0); send(8'h01, 0);
    chk("t3_err", {28'b0, error, in_ready, cpu_rst_n, busy}, 32'h8);
    chk("t3_wc", {16'b0, word_count}, 32'h0101);
    @(negedge clk); in_byte = 8'h55; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t3_err_hold", {30'b0, error, in_ready}, 32'd2);
    chk("t3_nowe", we_cnt - base, 32'd0);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    @(posedge clk); #1;
    chk("t3_done", {29'b0, done, cpu_rst_n, error}, 32'd6);
    chk("t3_d0", wd[base % 64], 32'h12345678);
    chk("t3_a0", {24'b0, wa[base % 64]}, 32'd0);

    // Test 4: gapped valid, byte offered while in WRITE
    base = we_cnt;
    pulse_start();
    send(8'h00, 1); send(8'h02, 1);
    send(8'hDE, 1); send(8'hAD, 1); send(8'hBE, 1); send(8'hEF, 1);
    chk("t4_write", {30'b0, imem_we, in_ready}, 32'd2);
    send(8'h01, 0);
    send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
    @(posedge clk); #1;
    chk("t4_done", {31'b0, done}, 32'd1);
    chk("t4_wecnt", we_cnt - base, 32'd2);
    chk("t4_d0", wd[base % 64], 32'hDEADBEEF);
    chk("t4_d1", wd[(base + 1) % 64], 32'h01020304);
    chk("t4_a1", {24'b0, wa[(base + 1) % 64]}, 32'd1);

    // Test 5: reset in the middle of a three-word load
    pulse_start();
    send(8'h00, 0); send(8'h03, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    chk("t5_inwrite", {31'b0, imem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_we", {31'b0, imem_we}, 32'd0);
    chk("t5_rst_wdata", imem_wdata, 32'd0);
    chk("t5_rst_wc", {16'b0, word_count}, 32'd0);
    chk("t5_rst_flags", {27'b0, busy, done, error, in_ready, cpu_rst_n}, 32'd0);
    @(negedge clk); rst = 1'b0;
    base = we_cnt;
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hCA, 0); send(8'hFE, 0); send(8'hBA, 0); send(8'hBE, 0);
    @(posedge clk); #1;
    chk("t5_done", {30'b0, done, cpu_rst_n}, 32'd3);
    chk("t5_d0", wd[base % 64], 32'hCAFEBABE);
    chk("t5_wecnt", we_cnt - base, 32'd1);

    // Test 6: start ignored in DATA, honoured in DONE
    base = we_cnt;
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h11, 0); send(8'h22, 0);
    pulse_start();
    chk("t6_ign", {30'b0, busy, in_ready}, 32'd3);
    chk("t6_wc", {16'b0, word_count}, 32'd1);
    send(8'h33, 0); send(8'h44, 0);
    @(posedge clk); #1;
    chk("t6_done", {30'b0, done, cpu_rst_n}, 32'd3);
    chk("t6_d0", wd[base % 64], 32'h11223344);
    pulse_start();
    chk("t6_reload", {29'b0, cpu_rst_n, done, busy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
